// File: rtl/stage1_preprocessor.sv
// Decode/operand stage ahead of the Stage 2 ALU: registers ALU operands and issues one-cycle unit strobes.
// Define PRE_MEM_TIMEOUT_EN to abort a memory wait after TIMEOUT_CYCLES cycles without data.
module stage1_preprocessor #(
    parameter int unsigned N              = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic [N-1:0] mem_data_in,
    input  logic         mem_data_valid,
    output logic [N-1:0] aluin1,
    output logic [N-1:0] aluin2,
    output logic [2:0]   operation,
    output logic [2:0]   opselect,
    output logic [4:0]   shift_number,
    output logic         enable_arith,
    output logic         enable_shift,
    output logic         mem_timeout
);

    localparam logic [2:0] OP_SHIFT   = 3'b000;
    localparam logic [2:0] OP_ARITH   = 3'b001;
    localparam logic [2:0] OP_MEMREAD = 3'b101;

    typedef enum logic [0:0] {
        IDLE,
        MEM_WAIT
    } state_t;

    state_t       state_q;
    logic [N-1:0] aluin1_q;
    logic [N-1:0] aluin2_q;
    logic [2:0]   operation_q;
    logic [2:0]   opselect_q;
    logic [4:0]   shift_number_q;
    logic         enable_arith_q;
    logic         enable_shift_q;
    logic [N-1:0] cap_src1_q;
    logic [2:0]   cap_op_q;

    logic [N-1:0] arith_b_d;
    logic [4:0]   shamt_d;

    // Register-field bits [15:12] carry nothing for this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[15:12];

`ifdef PRE_MEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] wait_cnt_q;
    logic          mem_timeout_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        arith_b_d = instr[11] ? {{(N-16){instr[31]}}, instr[31:16]} : src2;
        shamt_d   = instr[11] ? instr[10:6] : src2[4:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            aluin1_q       <= '0;
            aluin2_q       <= '0;
            operation_q    <= '0;
            opselect_q     <= '0;
            shift_number_q <= '0;
            enable_arith_q <= 1'b0;
            enable_shift_q <= 1'b0;
            cap_src1_q     <= '0;
            cap_op_q       <= '0;
`ifdef PRE_MEM_TIMEOUT_EN
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
`endif
        end else begin
            enable_arith_q <= 1'b0;
            enable_shift_q <= 1'b0;
`ifdef PRE_MEM_TIMEOUT_EN
            mem_timeout_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        case (instr[2:0])
                            OP_ARITH: begin
                                aluin1_q       <= src1;
                                aluin2_q       <= arith_b_d;
                                operation_q    <= instr[5:3];
                                opselect_q     <= OP_ARITH;
                                shift_number_q <= '0;
                                enable_arith_q <= 1'b1;
                            end
                            OP_SHIFT: begin
                                aluin1_q       <= src1;
                                aluin2_q       <= src2;
                                operation_q    <= instr[5:3];
                                opselect_q     <= OP_SHIFT;
                                shift_number_q <= shamt_d;
                                enable_shift_q <= 1'b1;
                            end
                            OP_MEMREAD: begin
                                cap_src1_q <= src1;
                                cap_op_q   <= instr[5:3];
                                state_q    <= MEM_WAIT;
`ifdef PRE_MEM_TIMEOUT_EN
                                wait_cnt_q <= '0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                MEM_WAIT: begin
                    if (mem_data_valid) begin
                        aluin1_q       <= cap_src1_q;
                        aluin2_q       <= mem_data_in;
                        operation_q    <= cap_op_q;
                        opselect_q     <= OP_MEMREAD;
                        shift_number_q <= '0;
                        enable_arith_q <= 1'b1;
                        state_q        <= IDLE;
`ifdef PRE_MEM_TIMEOUT_EN
                        wait_cnt_q     <= '0;
                    end else if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        // This cycle is the TIMEOUT_CYCLES-th without data.
                        mem_timeout_q <= 1'b1;
                        wait_cnt_q    <= '0;
                        state_q       <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready  = (state_q == IDLE);
    assign aluin1       = aluin1_q;
    assign aluin2       = aluin2_q;
    assign operation    = operation_q;
    assign opselect     = opselect_q;
    assign shift_number = shift_number_q;
    assign enable_arith = enable_arith_q;
    assign enable_shift = enable_shift_q;
`ifdef PRE_MEM_TIMEOUT_EN
    assign mem_timeout  = mem_timeout_q;
`else
    assign mem_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_stage1_preprocessor.sv
// Randomized and directed bench for stage1_preprocessor against a cycle-level behavioural model.
module tb_stage1_preprocessor;

    localparam int unsigned N = 32;
`ifdef PRE_MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [31:0]   instr = '0;
    logic [N-1:0]  src1 = '0;
    logic [N-1:0]  src2 = '0;
    logic [N-1:0]  mem_data_in = '0;
    logic          mem_data_valid = 1'b0;
    logic [N-1:0]  aluin1;
    logic [N-1:0]  aluin2;
    logic [2:0]    operation;
    logic [2:0]    opselect;
    logic [4:0]    shift_number;
    logic          enable_arith;
    logic          enable_shift;
    logic          mem_timeout;

    stage1_preprocessor #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .src1           (src1),
        .src2           (src2),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .aluin1         (aluin1),
        .aluin2         (aluin2),
        .operation      (operation),
        .opselect       (opselect),
        .shift_number   (shift_number),
        .enable_arith   (enable_arith),
        .enable_shift   (enable_shift),
        .mem_timeout    (mem_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: what the outputs must hold after each rising edge.
    logic [N-1:0] m_a1 = '0, m_a2 = '0, m_cap_a1 = '0;
    logic [2:0]   m_op = '0, m_os = '0, m_cap_op = '0;
    logic [4:0]   m_sh = '0;
    logic         m_ea = 0, m_es = 0, m_to = 0, m_busy = 0;
    int           m_wait = 0;

    function automatic logic [N-1:0] sext16(input logic [15:0] v);
        int s;
        s = int'(v) - (v[15] ? 65536 : 0);
        return N'(s);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_a1 = '0; m_a2 = '0; m_op = '0; m_os = '0; m_sh = '0;
            m_ea = 0; m_es = 0; m_to = 0; m_busy = 0; m_wait = 0;
        end else begin
            m_ea = 0; m_es = 0; m_to = 0;
            if (!m_busy) begin
                if (instr_valid) begin
                    if (instr[2:0] == 3'b001) begin
                        m_a1 = src1;
                        m_a2 = instr[11] ? sext16(instr[31:16]) : src2;
                        m_op = instr[5:3]; m_os = 3'b001; m_sh = 0; m_ea = 1;
                    end else if (instr[2:0] == 3'b000) begin
                        m_a1 = src1; m_a2 = src2;
                        m_op = instr[5:3]; m_os = 3'b000;
                        m_sh = instr[11] ? instr[10:6] : src2[4:0];
                        m_es = 1;
                    end else if (instr[2:0] == 3'b101) begin
                        m_busy = 1; m_wait = 0;
                        m_cap_a1 = src1; m_cap_op = instr[5:3];
                    end
                end
            end else if (mem_data_valid) begin
                m_a1 = m_cap_a1; m_a2 = mem_data_in;
                m_op = m_cap_op; m_os = 3'b101; m_sh = 0; m_ea = 1; m_busy = 0;
            end else begin
                m_wait++;
`ifdef PRE_MEM_TIMEOUT_EN
                if (m_wait == int'(TO)) begin
                    m_to = 1; m_busy = 0;
                end
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("instr_ready", 32'(instr_ready), 32'(!m_busy));
            check("aluin1", aluin1, m_a1);
            check("aluin2", aluin2, m_a2);
            check("operation", 32'(operation), 32'(m_op));
            check("opselect", 32'(opselect), 32'(m_os));
            check("shift_number", 32'(shift_number), 32'(m_sh));
            check("enable_arith", 32'(enable_arith), 32'(m_ea));
            check("enable_shift", 32'(enable_shift), 32'(m_es));
            check("mem_timeout", 32'(mem_timeout), 32'(m_to));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [15:0] imm, input logic immf,
                                       input logic [4:0] sh, input logic [2:0] op,
                                       input logic [2:0] os);
        return {imm, 4'h0, immf, sh, op, os};
    endfunction

    int ready_low;
    int pulses;

    initial begin
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_aluin1", aluin1, 32'd0);
        check("rst_strobes", {30'd0, enable_arith, enable_shift}, 32'd0);
        reset = 1'b0;

        // ARITH, register operand
        instr = mk(16'h0, 1'b0, 5'd0, 3'b000, 3'b001); src1 = 32'h10; src2 = 32'h22;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check("arith_a1", aluin1, 32'h10);
        check("arith_a2", aluin2, 32'h22);
        check("arith_strobe", {30'd0, enable_arith, enable_shift}, 32'd2);
        step();
        check("arith_strobe_off", 32'(enable_arith), 32'd0);
        check("arith_hold", aluin1, 32'h10);

        // ARITH, negative immediate
        instr = mk(16'h8001, 1'b1, 5'd0, 3'b010, 3'b001); src2 = 32'h1234;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check("arith_imm", aluin2, 32'hFFFF8001);
        check("model_imm", m_a2, 32'hFFFF8001);

        // Back-to-back SHIFTs
        instr = mk(16'h0, 1'b1, 5'd7, 3'b001, 3'b000); src2 = 32'h5;
        instr_valid = 1'b1;
        step();
        check("shift1_num", 32'(shift_number), 32'd7);
        check("shift1_strobe", 32'(enable_shift), 32'd1);
        instr = mk(16'h0, 1'b0, 5'd7, 3'b001, 3'b000); src2 = 32'h1F3;
        step();
        instr_valid = 1'b0;
        check("shift2_num", 32'(shift_number), 32'd19);
        check("shift2_strobe", 32'(enable_shift), 32'd1);
        step();
        check("shift_strobe_off", 32'(enable_shift), 32'd0);

        // MEMREAD, data on the fourth wait cycle; next instruction held meanwhile
        instr = mk(16'h0, 1'b0, 5'd0, 3'b010, 3'b101); src1 = 32'hABC;
        instr_valid = 1'b1;
        step();
        instr = mk(16'h0, 1'b0, 5'd0, 3'b100, 3'b001); src1 = 32'h77; src2 = 32'h88;
        ready_low = 0; pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (!instr_ready) ready_low++;
            if (enable_arith || enable_shift) pulses++;
            step();
        end
        if (!instr_ready) ready_low++;
        mem_data_in = 32'hDEADBEEF; mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        check("mem_ready_low", 32'(ready_low), 32'd4);
        check("mem_no_early_strobe", 32'(pulses), 32'd0);
        check("mem_a2", aluin2, 32'hDEADBEEF);
        check("mem_a1", aluin1, 32'hABC);
        check("mem_strobe", {30'd0, enable_arith, enable_shift}, 32'd2);
        check("mem_ready_back", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        check("held_accept_a1", aluin1, 32'h77);
        check("held_accept_op", 32'(operation), 32'd4);

        // Reset mid-wait, with data present on the reset edge
        instr = mk(16'h0, 1'b0, 5'd0, 3'b011, 3'b101); src1 = 32'h5A5A;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        reset = 1'b1; mem_data_valid = 1'b1; mem_data_in = 32'h1111;
        step();
        reset = 1'b0; mem_data_valid = 1'b0;
        check("rst_wait_ready", 32'(instr_ready), 32'd1);
        check("rst_wait_a1", aluin1, 32'd0);
        check("rst_wait_a2", aluin2, 32'd0);
        check("rst_wait_strobe", {30'd0, enable_arith, enable_shift}, 32'd0);

        // Illegal opselect leaves everything as it was
        instr = mk(16'h0, 1'b0, 5'd0, 3'b011, 3'b001); src1 = 32'h55; src2 = 32'h66;
        instr_valid = 1'b1;
        step();
        instr = mk(16'hFFFF, 1'b1, 5'd9, 3'b110, 3'b111); src1 = 32'h99; src2 = 32'hAA;
        step();
        instr_valid = 1'b0;
        check("illegal_a1", aluin1, 32'h55);
        check("illegal_a2", aluin2, 32'h66);
        check("illegal_op", 32'(operation), 32'd3);
        check("illegal_os", 32'(opselect), 32'd1);
        check("illegal_strobe", {30'd0, enable_arith, enable_shift}, 32'd0);
        check("illegal_ready", 32'(instr_ready), 32'd1);

`ifdef PRE_MEM_TIMEOUT_EN
        instr = mk(16'h0, 1'b0, 5'd0, 3'b001, 3'b101);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_timeout) pulses++;
            if (enable_arith || enable_shift) pulses += 10;
        end
        check("timeout_pulses", 32'(pulses), 32'd1);
        check("timeout_ready", 32'(instr_ready), 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [31:0] w;
            w = $urandom;
            sel = $urandom_range(0, 9);
            w[2:0] = (sel < 4) ? 3'b001 : (sel < 7) ? 3'b000 : (sel < 9) ? 3'b101 : 3'($urandom);
            instr = w;
            instr_valid = ($urandom_range(0, 3) != 0);
            src1 = $urandom; src2 = $urandom;
            mem_data_in = $urandom;
            mem_data_valid = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; instr_valid = 1'b0; mem_data_valid = 1'b0;
        step();
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stage1_preprocessor.md
# stage1_preprocessor

Decode-and-operand stage that sits directly upstream of the Stage 2 ALU. It accepts one instruction per handshake, selects operands from the register sources, the sign-extended immediate or returned memory data, and presents registered `aluin1`/`aluin2`/`operation`/`opselect`/`shift_number` with single-cycle `enable_arith`/`enable_shift` strobes. Memory-read instructions stall the stage until memory data returns.

## Interface
- `N`, 32: datapath width.
- `TIMEOUT_CYCLES`, 16: maximum `MEM_WAIT` cycles before abort; used only with `PRE_MEM_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction and sources valid.
- `instr_ready` out 1: stage can accept this cycle.
- `instr` in 32: instruction word.
- `src1` in N: first register operand.
- `src2` in N: second register operand.
- `mem_data_in` in N: memory read data.
- `mem_data_valid` in 1: `mem_data_in` valid this cycle.
- `aluin1` out N: ALU operand 1.
- `aluin2` out N: ALU operand 2.
- `operation` out 3: ALU operation code.
- `opselect` out 3: ALU operation class.
- `shift_number` out 5: shift amount.
- `enable_arith` out 1: one-cycle strobe for the arithmetic/logic unit.
- `enable_shift` out 1: one-cycle strobe for the shift unit.
- `mem_timeout` out 1: one-cycle abort pulse.

## Operation
- Instruction fields:
  - `instr[2:0]` gives `opselect`.
  - `instr[5:3]` gives `operation`.
  - `instr[10:6]` gives the immediate shift amount.
  - `instr[11]` is the immediate flag.
  - `instr[31:16]` is the 16-bit immediate.
- `opselect` classes:
  - SHIFT = 3'b000.
  - ARITH = 3'b001.
  - MEMREAD = 3'b101.
  - All other codes are illegal.
- Accept occurs when `instr_valid && instr_ready`.
- ARITH accept:
  - `aluin1` = `src1`.
  - `aluin2` = imm flag ? sign-extended `instr[31:16]` : `src2`.
  - `enable_arith` = 1 for one cycle.
- SHIFT accept:
  - `aluin1` = `src1`.
  - `aluin2` = `src2`.
  - `shift_number` = imm flag ? `instr[10:6]` : `src2[4:0]`.
  - `enable_shift` = 1 for one cycle.
- MEMREAD accept: capture `src1`, `operation` and `opselect`, then enter `MEM_WAIT`. No strobe is issued yet.
- Illegal `opselect` accept: the instruction is consumed and dropped. No strobe is issued, and all data outputs hold.
- FSM states:
  - `IDLE`: `instr_ready`=1. A MEMREAD accept moves to `MEM_WAIT`; any other accept stays in `IDLE`.
  - `MEM_WAIT`: `instr_ready`=0. On `mem_data_valid`=1: `aluin1` = captured `src1`, `aluin2` = `mem_data_in`, `enable_arith` = 1, return to `IDLE`.
- Register update rules:
  - `aluin1`, `aluin2`, `operation`, `opselect` and `shift_number` are registered.
  - They update only on an issuing event, i.e. the same cycle a strobe is set.
  - They hold otherwise, because the ALU uses the held values after the strobe.
  - `shift_number` is cleared to 0 on ARITH and MEMREAD issue.
- `enable_arith` and `enable_shift` are never both 1.
- `mem_data_valid` is ignored in `IDLE`.

## Timing
- Reset values: all outputs 0, except `instr_ready`=1 (FSM in `IDLE`). Any internal wait counter is 0.
- Latency:
  - ARITH/SHIFT: accept at edge k → outputs and strobe visible after edge k, for exactly one cycle.
  - MEMREAD: data sampled at edge m → outputs and strobe visible after edge m.
- Throughput: back-to-back ARITH/SHIFT accepts every cycle, giving one strobe per cycle.
- `instr_ready` is the registered FSM state.
  - It is 0 the cycle after a MEMREAD accept.
  - It is 1 again the cycle after the data or abort edge.
- `mem_data_valid` on the first `MEM_WAIT` cycle completes the read. The minimum MEMREAD occupancy is therefore 2 cycles.
- Reset asserted mid-`MEM_WAIT`: return to `IDLE`, discard the captured instruction, no strobe. Outputs take their reset values.
- `instr_valid` during `MEM_WAIT`: not accepted. The upstream holds the instruction.

## Configuration
- `PRE_MEM_TIMEOUT_EN` defined:
  - A counter increments each `MEM_WAIT` cycle without `mem_data_valid`.
  - When the count reaches `TIMEOUT_CYCLES`, the stage pulses `mem_timeout` for one cycle, returns to `IDLE` and issues no strobe.
  - If `mem_data_valid` arrives on the same cycle as the limit, the data wins and no timeout occurs.
- `PRE_MEM_TIMEOUT_EN` undefined:
  - `MEM_WAIT` waits indefinitely.
  - `mem_timeout` is tied to 0.

## Test plan
- ARITH, imm=0, `src1`=0x10, `src2`=0x22, `instr[5:3]`=3'b000 → next cycle: `aluin1`=0x10, `aluin2`=0x22, `enable_arith`=1 for one cycle, `enable_shift`=0.
- ARITH, imm=1, `instr[31:16]`=0x8001 → `aluin2`=0xFFFF8001.
- SHIFT, then SHIFT on consecutive cycles, with imm=1/`instr[10:6]`=5'd7 then imm=0/`src2`=0x1F3 → `shift_number` 7 then 19, `enable_shift` high for two consecutive cycles.
- MEMREAD with `mem_data_valid` after 3 cycles and `mem_data_in`=0xDEADBEEF → `instr_ready` low for 4 cycles; one `enable_arith` pulse with `aluin2`=0xDEADBEEF; an `instr_valid` held high during the wait is accepted only after return to `IDLE`.
- Reset during `MEM_WAIT` → no strobe, `instr_ready`=1 after the reset edge, all outputs 0.
- With `PRE_MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, MEMREAD with no data → `mem_timeout` pulses once, no strobe, `instr_ready` returns to 1. Illegal `opselect` 3'b111 → consumed, no strobe, outputs unchanged.
